conv_stream_engine: RTL and testbench
=====================================

// Module: conv_stream_engine
// PURPOSE
// Streaming KSIZE x KSIZE 2-D convolution engine for the image-convolution processor.
// - Replaces the microcoded load/multiply/accumulate loop over K0..K8, P1..P3 and AC with a pipelined datapath.
// - Accepts raster-order pixels over a valid/ready stream and buffers KSIZE-1 rows internally.
// - Emits one saturated output pixel per valid window ("valid" convolution, no padding).
// PARAMETERS
// DATA_W  8   pixel width; unsigned in and out
// COEF_W  8   kernel coefficient width, two's complement
// KSIZE   3   kernel edge length, odd, 3..7
// IMG_W   16  image width in pixels, >= KSIZE
// IMG_H   16  image height in pixels, >= KSIZE
// ACC_W   32  signed accumulator width; must hold KSIZE^2 full-scale products
// PORTS
// clk        in   1                    single clock, all state on rising edge
// rst_n      in   1                    synchronous active-low reset
// start      in   1                    begin a frame; honoured only in IDLE
// k_we       in   1                    kernel coefficient write strobe; honoured only in IDLE
// k_addr     in   clog2(KSIZE^2)       coefficient index, row-major, 0 = top-left
// k_data     in   COEF_W               coefficient value
// shift      in   5                    arithmetic right shift applied to sum; sampled at start
// pix_valid  in   1                    input pixel valid
// pix_ready  out  1                    engine accepts pixel this cycle
// pix_data   in   DATA_W               input pixel
// out_valid  out  1                    output pixel valid
// out_ready  in   1                    downstream accepts output
// out_data   out  DATA_W               convolved, shifted, saturated pixel
// busy       out  1                    high in any state other than IDLE
// done       out  1                    one-cycle pulse at frame end
// BEHAVIOUR
// Reset (rst_n=0 at a clk edge):
// - State -> IDLE; row/col counters = 0; line buffers and window treated as empty.
// - Kernel registers = 0; latched shift = 0.
// - Outputs: pix_ready=0, out_valid=0, out_data=0, busy=0, done=0.
// - Reset mid-frame aborts the frame; no partial output is presented after reset.
// States:
// - IDLE: on start -> RUN; clear counters; latch shift.
// - RUN: accept pixels; after the pixel at (IMG_H-1, IMG_W-1) is accepted -> FLUSH.
// - FLUSH: wait until out_valid=0 or the final out handshake completes -> DONE.
// - DONE: done=1 for exactly one cycle -> IDLE.
// Input handshake:
// - pix_ready = (state==RUN) && (!out_valid || out_ready).
// - A pixel transfers when pix_valid && pix_ready; col wraps IMG_W-1 -> 0 and increments row.
// Windowing:
// - A window is complete on transfer of pixel (r,c) with r>=KSIZE-1 and c>=KSIZE-1.
// - Window = rows r-KSIZE+1..r, cols c-KSIZE+1..c.
// - No window forms across the row wrap.
// Arithmetic:
// - sum = SUM k[i][j] * zero_ext(pix); signed, ACC_W wide.
// - res = sum >>> shift.
// - out = 0 if res<0; (2^DATA_W)-1 if res>2^DATA_W-1; else res[DATA_W-1:0].
// Output:
// - Single registered stage: out_valid rises the cycle after the completing pixel transfer (latency 1).
// - out_data is held stable while out_valid && !out_ready.
// - Simultaneous out handshake and new completing pixel: output register reloads, out_valid stays 1.
// Frame size: exactly (IMG_W-KSIZE+1)*(IMG_H-KSIZE+1) outputs per frame.
// Ignored inputs:
// - start while busy, k_we while busy, pix_valid outside RUN.
// TESTING (bench: IMG_W=IMG_H=5, KSIZE=3, pixel(r,c)=5r+c)
// - Identity kernel (k[4]=1, rest 0), shift=0 -> 9 outputs 6,7,8,11,12,13,16,17,18; done pulses once; busy falls with it.
// - All-ones kernel, shift=0 -> 54,63,72,99,108,117,144,153,162.
// - Saturation, all pixels 255:
//   - all-ones kernel, shift=3 -> 255 (2295>>>3=286);
//   - shift=4 -> 143;
//   - k[4]=-1, rest 0 -> 0.
// - Backpressure: out_ready=0 for 5 cycles after first out_valid -> pix_ready=0, out_data held at 6; resume gives the full sequence, no loss or duplicates.
// - Pixel gaps: pix_valid toggled 1/0 every cycle -> same 9 outputs; k_we and start pulsed mid-frame are ignored (outputs unchanged).
// - Reset mid-frame: rst_n=0 for 1 cycle after 12 pixels -> all outputs 0, state IDLE, kernel cleared; new frame with identity kernel reloaded produces correct results.

Source files
------------

// File: rtl/conv_stream_engine.sv
// Streaming KSIZE x KSIZE valid-mode 2-D convolution over a raster-order pixel stream.
// KSIZE-1 line buffers feed a sliding window; one registered, saturated result per complete window.
module conv_stream_engine #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int KSIZE  = 3,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ACC_W  = 32,
    parameter int KA_W   = $clog2(KSIZE * KSIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              k_we,
    input  logic [KA_W-1:0]   k_addr,
    input  logic [COEF_W-1:0] k_data,
    input  logic [4:0]        shift,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int NTAP   = KSIZE * KSIZE;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int PROD_W = COEF_W + DATA_W + 1;
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [4:0]          shift_q, shift_d;
    logic [COEF_W-1:0]   kern_q [NTAP];
    logic [COEF_W-1:0]   kern_d [NTAP];
    logic [DATA_W-1:0]   win_q  [KSIZE][KSIZE];
    logic [DATA_W-1:0]   win_d  [KSIZE][KSIZE];
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   line_mem [0:KSIZE-2][0:IMG_W-1];
    logic [DATA_W-1:0]   new_col  [KSIZE];
    logic [DATA_W-1:0]   win_sh   [KSIZE][KSIZE];
    logic signed [PROD_W-1:0] prod [NTAP];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  res;
    logic [DATA_W-1:0]   sat;

    logic pix_xfer;
    logic out_fire;
    logic win_done;
    logic last_pix;

    assign pix_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign pix_xfer  = pix_valid && pix_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign win_done  = pix_xfer && (row_q >= ROW_W'(KSIZE - 1)) && (col_q >= COL_W'(KSIZE - 1));
    assign last_pix  = pix_xfer && (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Row 0 of the window is the oldest image row; line_mem[0] holds the row just above the input.
    genvar gi, gj;
    generate
        for (gi = 0; gi < KSIZE - 1; gi++) begin : g_col
            assign new_col[gi] = line_mem[KSIZE-2-gi][col_q];
        end
        assign new_col[KSIZE-1] = pix_data;

        for (gi = 0; gi < KSIZE; gi++) begin : g_row
            for (gj = 0; gj < KSIZE; gj++) begin : g_tap
                if (gj < KSIZE - 1) begin : g_shift
                    assign win_sh[gi][gj] = win_q[gi][gj+1];
                end else begin : g_new
                    assign win_sh[gi][gj] = new_col[gi];
                end
            end
        end

        for (gi = 0; gi < NTAP; gi++) begin : g_mul
            assign prod[gi] = $signed(kern_q[gi]) * $signed({1'b0, win_sh[gi / KSIZE][gi % KSIZE]});
        end
    endgenerate

    always_comb begin
        acc = '0;
        for (int i = 0; i < NTAP; i++) begin
            acc = acc + ACC_W'(prod[i]);
        end
    end

    assign res = acc >>> shift_q;

    always_comb begin
        sat = res[DATA_W-1:0];
        if (res[ACC_W-1]) begin
            sat = '0;
        end else if (res > PIX_MAX) begin
            sat = '1;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        shift_d     = shift_q;
        kern_d      = kern_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        case (state_q)
            S_IDLE: begin
                for (int i = 0; i < NTAP; i++) begin
                    if (k_we && (k_addr == KA_W'(i))) begin
                        kern_d[i] = k_data;
                    end
                end
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                    shift_d = shift;
                end
            end
            S_RUN: begin
                if (last_pix) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!out_valid_q || out_fire) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pix_xfer) begin
            win_d = win_sh;
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A new result may land in the same cycle the previous one is consumed.
        if (win_done) begin
            out_valid_d = 1'b1;
            out_data_d  = sat;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            shift_q     <= '0;
            kern_q      <= '{default: '0};
            win_q       <= '{default: '{default: '0}};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            shift_q     <= shift_d;
            kern_q      <= kern_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Line buffers carry no reset; their contents are only used once the row counter proves them filled.
    always_ff @(posedge clk) begin
        if (rst_n && pix_xfer) begin
            line_mem[0][col_q] <= pix_data;
            for (int i = 1; i < KSIZE - 1; i++) begin
                line_mem[i][col_q] <= line_mem[i-1][col_q];
            end
        end
    end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Directed bench for conv_stream_engine on a 5x5 image with a 3x3 kernel, pixel(r,c) = 5r+c.
module tb_conv_stream_engine;

    localparam int DW  = 8;
    localparam int CW  = 8;
    localparam int KS  = 3;
    localparam int IW  = 5;
    localparam int IH  = 5;
    localparam int AW  = 32;
    localparam int KAW = 4;
    localparam int NPIX = IW * IH;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          k_we;
    logic [KAW-1:0] k_addr;
    logic [CW-1:0] k_data;
    logic [4:0]    shift;
    logic          pix_valid;
    logic          pix_ready;
    logic [DW-1:0] pix_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    conv_stream_engine #(
        .DATA_W(DW), .COEF_W(CW), .KSIZE(KS), .IMG_W(IW), .IMG_H(IH), .ACC_W(AW), .KA_W(KAW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_we(k_we), .k_addr(k_addr),
        .k_data(k_data), .shift(shift), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] got [$];
    int            done_cnt;
    bit            busy_after_bad;
    bit            busy_early_low;
    bit            timed_out;
    int            stall_cnt;
    bit            stall_ready_seen;
    bit            stall_data_bad;
    logic [DW-1:0] stall_data;

    localparam int EXP_ID  [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    localparam int EXP_ONE [9] = '{54, 63, 72, 99, 108, 117, 144, 153, 162};

    task automatic load_kernel(input logic [CW-1:0] k [9]);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            k_we   = 1'b1;
            k_addr = KAW'(i);
            k_data = k[i];
        end
        @(negedge clk);
        k_we = 1'b0;
    endtask

    // Drives one frame and records accepted outputs plus handshake observations.
    task automatic run_frame(input logic [4:0] sh, input bit all_max, input bit gaps,
                             input int bp_len, input bit junk, input int abort_after);
        int  idx;
        bit  saw_done;
        got.delete();
        done_cnt = 0; busy_after_bad = 0; busy_early_low = 0; timed_out = 0;
        stall_cnt = 0; stall_ready_seen = 0; stall_data_bad = 0; stall_data = '0;
        idx = 0; saw_done = 0;
        @(negedge clk);
        start = 1'b1;
        shift = sh;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            start     = 1'b0;
            shift     = 5'd0;
            k_we      = 1'b0;
            pix_valid = (idx < NPIX) && (!gaps || (cyc % 2 == 0));
            pix_data  = all_max ? 8'hFF : 8'(idx);
            out_ready = !(bp_len > 0 && stall_cnt < bp_len);
            if (junk && cyc == 7) begin
                k_we   = 1'b1;
                k_addr = '0;
                k_data = 8'd100;
                start  = 1'b1;
            end
            #1;
            if (!out_ready && out_valid) begin
                if (stall_cnt == 0) stall_data = out_data;
                else if (out_data !== stall_data) stall_data_bad = 1;
                if (pix_ready) stall_ready_seen = 1;
                stall_cnt++;
            end
            if (out_valid && out_ready) got.push_back(out_data);
            if (done) done_cnt++;
            if (saw_done) begin
                if (busy !== 1'b0) busy_after_bad = 1;
                break;
            end
            if (done) saw_done = 1;
            else if (!busy) busy_early_low = 1;
            if (pix_valid && pix_ready) begin
                idx++;
                if (abort_after > 0 && idx == abort_after) break;
            end
            if (cyc == 399) timed_out = 1;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        k_we      = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        n_checks++;
        if ({pix_ready, out_valid, busy, done} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {pix_ready, out_valid, busy, done});
        else n_pass++;
        n_checks++;
        if (out_data !== 8'd0) $display("FAIL reset_out_data: got %0d expected 0", out_data);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        logic [CW-1:0] k [9];
        k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_kernel(k);
        run_frame(5'd0, 1'b0, 1'b0, 0, 1'b0, 0);
        n_checks++;
        if (got.size() !== 9) $display("FAIL ident_count: got %0d expected 9", got.size());
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (((i < got.size()) ? got[i] : 8'hxx) !== 8'(EXP_ID[i]))
                $display("FAIL ident_out%0d: got %0d expected %0d", i, (i < got.size()) ? got[i] : 8'hxx, EXP_ID[i]);
            else n_pass++;
        end
        n_checks++;
        if (done_cnt !== 1 || timed_out) $display("FAIL ident_done: got %0d pulses expected 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (busy_after_bad || busy_early_low)
            $display("FAIL ident_busy: got early_low=%0d after_high=%0d expected 0 0", busy_early_low, busy_after_bad);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] k [9];
        k = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        load_kernel(k);
        run_frame(5'd0, 1'b0, 1'b0, 0, 1'b0, 0);
        n_checks++;
        if (got.size() !== 9) $display("FAIL ones_count: got %0d expected 9", got.size());
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (((i < got.size()) ? got[i] : 8'hxx) !== 8'(EXP_ONE[i]))
                $display("FAIL ones_out%0d: got %0d expected %0d", i, (i < got.size()) ? got[i] : 8'hxx, EXP_ONE[i]);
            else n_pass++;
        end
        n_checks++;
        if (done_cnt !== 1) $display("FAIL ones_done: got %0d pulses expected 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [CW-1:0] k [9];
        int            exp_v [3];
        logic [4:0]    sh_v [3];
        exp_v = '{255, 143, 0};
        sh_v  = '{5'd3, 5'd4, 5'd0};
        for (int t = 0; t < 3; t++) begin
            if (t == 2) k = '{0, 0, 0, 0, 8'hFF, 0, 0, 0, 0};
            else        k = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
            load_kernel(k);
            run_frame(sh_v[t], 1'b1, 1'b0, 0, 1'b0, 0);
            n_checks++;
            if (got.size() !== 9) $display("FAIL sat%0d_count: got %0d expected 9", t, got.size());
            else n_pass++;
            for (int i = 0; i < 9; i++) begin
                n_checks++;
                if (((i < got.size()) ? got[i] : 8'hxx) !== 8'(exp_v[t]))
                    $display("FAIL sat%0d_out%0d: got %0d expected %0d", t, i, (i < got.size()) ? got[i] : 8'hxx, exp_v[t]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] k [9];
        k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_kernel(k);
        run_frame(5'd0, 1'b0, 1'b0, 5, 1'b0, 0);
        n_checks++;
        if (stall_cnt !== 5) $display("FAIL bp_stalls: got %0d expected 5", stall_cnt);
        else n_pass++;
        n_checks++;
        if (stall_ready_seen) $display("FAIL bp_pix_ready: got 1 expected 0 while stalled");
        else n_pass++;
        n_checks++;
        if (stall_data !== 8'd6 || stall_data_bad)
            $display("FAIL bp_hold: got %0d (changed=%0d) expected 6 held", stall_data, stall_data_bad);
        else n_pass++;
        n_checks++;
        if (got.size() !== 9) $display("FAIL bp_count: got %0d expected 9", got.size());
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (((i < got.size()) ? got[i] : 8'hxx) !== 8'(EXP_ID[i]))
                $display("FAIL bp_out%0d: got %0d expected %0d", i, (i < got.size()) ? got[i] : 8'hxx, EXP_ID[i]);
            else n_pass++;
        end
    endtask

    task automatic test_gaps_ignored();
        run_frame(5'd0, 1'b0, 1'b1, 0, 1'b1, 0);
        n_checks++;
        if (got.size() !== 9) $display("FAIL gap_count: got %0d expected 9", got.size());
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (((i < got.size()) ? got[i] : 8'hxx) !== 8'(EXP_ID[i]))
                $display("FAIL gap_out%0d: got %0d expected %0d", i, (i < got.size()) ? got[i] : 8'hxx, EXP_ID[i]);
            else n_pass++;
        end
        n_checks++;
        if (done_cnt !== 1) $display("FAIL gap_done: got %0d pulses expected 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        logic [CW-1:0] k [9];
        run_frame(5'd0, 1'b0, 1'b0, 0, 1'b0, 12);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({pix_ready, out_valid, busy, done} !== 4'b0000)
            $display("FAIL mid_reset_flags: got %b expected 0000", {pix_ready, out_valid, busy, done});
        else n_pass++;
        n_checks++;
        if (out_data !== 8'd0) $display("FAIL mid_reset_data: got %0d expected 0", out_data);
        else n_pass++;
        @(negedge clk);
        rst_n     = 1'b1;
        pix_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({pix_ready, out_valid, busy} !== 3'b000)
            $display("FAIL mid_reset_idle: got %b expected 000", {pix_ready, out_valid, busy});
        else n_pass++;
        pix_valid = 1'b0;
        // Kernel was cleared, so a frame without reloading must produce zeros.
        run_frame(5'd0, 1'b0, 1'b0, 0, 1'b0, 0);
        n_checks++;
        if (got.size() !== 9) $display("FAIL clr_count: got %0d expected 9", got.size());
        else n_pass++;
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (((i < got.size()) ? got[i] : 8'hxx) !== 8'd0)
                $display("FAIL clr_out%0d: got %0d expected 0", i, (i < got.size()) ? got[i] : 8'hxx);
            else n_pass++;
        end
        k = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        load_kernel(k);
        run_frame(5'd0, 1'b0, 1'b0, 0, 1'b0, 0);
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (((i < got.size()) ? got[i] : 8'hxx) !== 8'(EXP_ID[i]))
                $display("FAIL reload_out%0d: got %0d expected %0d", i, (i < got.size()) ? got[i] : 8'hxx, EXP_ID[i]);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        k_we      = 1'b0;
        k_addr    = '0;
        k_data    = '0;
        shift     = '0;
        pix_valid = 1'b0;
        pix_data  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        test_identity();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_gaps_ignored();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
